// File: rtl/vga_pkg.sv
// ============================================================================
//  Module   : vga_pkg
//  Brief    : Shared 640x480@60 timing constants and coordinate/colour types.
//             Compiles the colour-bar helper only when VGA_TEST_PATTERN_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int H_ACTIVE_PX = 640;
    localparam int H_FP_PX     = 16;
    localparam int H_SYNC_PX   = 96;
    localparam int H_BP_PX     = 48;
    localparam int V_ACTIVE_LN = 480;
    localparam int V_FP_LN     = 10;
    localparam int V_SYNC_LN   = 2;
    localparam int V_BP_LN     = 33;

    localparam int H_TOTAL = H_ACTIVE_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;
    localparam int V_TOTAL = V_ACTIVE_LN + V_FP_LN + V_SYNC_LN + V_BP_LN;

    typedef logic [9:0]  coord_x_t;
    typedef logic [8:0]  coord_y_t;
    typedef logic [11:0] rgb_t;

`ifdef VGA_TEST_PATTERN_EN
    // Eight 80-pixel bars: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_colour(input logic [9:0] h);
        rgb_t c;
        if      (h < 10'd80)  c = 12'hFFF;
        else if (h < 10'd160) c = 12'hFF0;
        else if (h < 10'd240) c = 12'h0FF;
        else if (h < 10'd320) c = 12'h0F0;
        else if (h < 10'd400) c = 12'hF0F;
        else if (h < 10'd480) c = 12'hF00;
        else if (h < 10'd560) c = 12'h00F;
        else                  c = 12'h000;
        return c;
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/vga_clk_en.sv
// ============================================================================
//  Module   : vga_clk_en
//  Brief    : Pixel-tick divider; pix_ce pulses once every CLK_DIV clocks and
//             pre_ce one clock earlier (CLK_DIV must be at least 2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_ce,
    output logic pre_ce
);

    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [C_DIV_W-1:0] div_q;
    logic [C_DIV_W-1:0] div_d;

    assign pix_ce = (div_q == C_DIV_W'(CLK_DIV - 1));
    assign pre_ce = (div_q == C_DIV_W'(CLK_DIV - 2));

    always_comb begin
        div_d = div_q + 1'b1;
        if (pix_ce) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// ============================================================================
//  Module   : vga_timing_ctrl
//  Brief    : VGA raster timing, renderer coordinates and registered DAC stage.
//             Define VGA_TEST_PATTERN_EN to build the colour-bar source on test_mode.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE_PX,
    parameter int H_FP     = vga_pkg::H_FP_PX,
    parameter int H_SYNC   = vga_pkg::H_SYNC_PX,
    parameter int H_BP     = vga_pkg::H_BP_PX,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE_LN,
    parameter int V_FP     = vga_pkg::V_FP_LN,
    parameter int V_SYNC   = vga_pkg::V_SYNC_LN,
    parameter int V_BP     = vga_pkg::V_BP_LN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rgb_in,
    input  logic        test_mode,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_valid,
    output logic        pix_ce,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    import vga_pkg::*;

    localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] C_H_LAST     = 10'(C_H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST     = 10'(C_V_TOTAL - 1);
    localparam logic [9:0] C_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] C_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       w_pix_ce;
    logic       w_pre_ce;

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    coord_x_t   pix_x_q, pix_x_d;
    coord_y_t   pix_y_q, pix_y_d;
    logic       pix_valid_q, pix_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    rgb_t       rgb_q, rgb_d;

    logic       w_active_now;
    logic       w_active_next;
    logic       w_hsync_raw;
    logic       w_vsync_raw;
    rgb_t       w_src;

    vga_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (w_pix_ce),
        .pre_ce (w_pre_ce)
    );

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (w_pix_ce) begin
            if (h_cnt_q == C_H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == C_V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    assign w_active_now  = (h_cnt_q < C_H_ACT) && (v_cnt_q < C_V_ACT);
    assign w_active_next = (h_cnt_d < C_H_ACT) && (v_cnt_d < C_V_ACT);
    assign w_hsync_raw   = !((h_cnt_q >= C_HS_START) && (h_cnt_q < C_HS_END));
    assign w_vsync_raw   = !((v_cnt_q >= C_VS_START) && (v_cnt_q < C_VS_END));

`ifdef VGA_TEST_PATTERN_EN
    assign w_src = test_mode ? bar_colour(h_cnt_q) : rgb_in;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_src              = rgb_in;
`endif

    // Coordinates follow the counters' next value so they change on the same
    // edge as the counters, leaving the renderer the whole tick to respond.
    always_comb begin
        pix_valid_d   = w_active_next;
        pix_x_d       = w_active_next ? h_cnt_d : '0;
        pix_y_d       = w_active_next ? v_cnt_d[8:0] : '0;
        frame_start_d = w_pre_ce && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        if (w_pix_ce) begin
            hsync_d = w_hsync_raw;
            vsync_d = w_vsync_raw;
            rgb_d   = w_active_now ? w_src : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign pix_ce      = w_pix_ce;
    assign frame_start = frame_start_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// ============================================================================
//  Module   : tb_vga_timing_ctrl
//  Brief    : Bench for vga_timing_ctrl: a default-timing instance and a
//             reduced-timing instance checked against a clock-count raster model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_ctrl;

    localparam int DIV = 4;
    localparam int S_HA = 40, S_HFP = 4, S_HS = 8, S_HBP = 4;
    localparam int S_VA = 12, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_FT = S_HT * (S_VA + S_VFP + S_VS + S_VBP);
    localparam logic [35:0] RST_VEC = {10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};

`ifdef VGA_TEST_PATTERN_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] rgb_in;
    logic        test_mode;

    logic [9:0] d_x, s_x;
    logic [8:0] d_y, s_y;
    logic       d_valid, s_valid, d_ce, s_ce, d_fs, s_fs, d_hs, s_hs, d_vs, s_vs;
    logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

    int errors = 0;
    int checks = 0;
    int k;
    logic [11:0] cap_d, cap_s;
    logic        hs_prev, vs_prev;
    int          hs_falls, hs_last, vs_last, fs_n, fs_last;

    always #5 clk = ~clk;

    vga_timing_ctrl u_dut_dflt (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .test_mode(test_mode),
        .pix_x(d_x), .pix_y(d_y), .pix_valid(d_valid), .pix_ce(d_ce),
        .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    vga_timing_ctrl #(
        .CLK_DIV(DIV), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) u_dut_small (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .test_mode(test_mode),
        .pix_x(s_x), .pix_y(s_y), .pix_valid(s_valid), .pix_ce(s_ce),
        .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // Expected outputs k clocks after reset release, purely from raster position.
    function automatic logic [35:0] model(input int kk, input int ha, input int hfp,
                                          input int hsw, input int hbp, input int va,
                                          input int vfp, input int vsw, input int vbp,
                                          input logic [11:0] cap);
        int ht, ft, tick, pos, h, v, ph, pv;
        logic act, ce, fs, hs, vs;
        logic [9:0] px;
        logic [8:0] py;
        logic [11:0] col;
        ht   = ha + hfp + hsw + hbp;
        ft   = ht * (va + vfp + vsw + vbp);
        tick = kk / DIV;
        pos  = tick % ft;
        h    = pos % ht;
        v    = pos / ht;
        act  = (kk > 0) && (h < ha) && (v < va);
        ce   = (kk % DIV) == DIV - 1;
        fs   = ce && (pos == 0);
        px   = act ? 10'(h) : 10'd0;
        py   = act ? 9'(v) : 9'd0;
        hs   = 1'b1;
        vs   = 1'b1;
        col  = 12'h000;
        if (tick > 0) begin
            pos = (tick - 1) % ft;
            ph  = pos % ht;
            pv  = pos / ht;
            hs  = !((ph >= ha + hfp) && (ph < ha + hfp + hsw));
            vs  = !((pv >= va + vfp) && (pv < va + vfp + vsw));
            col = ((ph < ha) && (pv < va)) ? cap : 12'h000;
        end
        return {px, py, act, ce, fs, hs, vs, col};
    endfunction

    function automatic logic [11:0] bar(input int h);
        case (h / 80)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [35:0] exp_d(input int kk);
        return model(kk, 640, 16, 96, 48, 480, 10, 2, 33, cap_d);
    endfunction

    function automatic logic [35:0] exp_s(input int kk);
        return model(kk, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, cap_s);
    endfunction

    function automatic logic [35:0] got_d();
        return {d_x, d_y, d_valid, d_ce, d_fs, d_hs, d_vs, d_r, d_g, d_b};
    endfunction

    function automatic logic [35:0] got_s();
        return {s_x, s_y, s_valid, s_ce, s_fs, s_hs, s_vs, s_r, s_g, s_b};
    endfunction

    task automatic restart_tracking();
        k = 0;
        cap_d = 12'h000;
        cap_s = 12'h000;
        hs_prev = 1'b1;
        vs_prev = 1'b1;
        hs_falls = 0;
        hs_last = 0;
        vs_last = 0;
        fs_n = 0;
        fs_last = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("raster_dflt", got_d(), exp_d(k));
            check_eq("raster_small", got_s(), exp_s(k));
            if (hs_prev && !d_hs) begin
                hs_falls++;
                if (hs_falls == 1) check_eq("hsync_first_fall", k, (640 + 16 + 1) * DIV);
                else               check_eq("hsync_period", k - hs_last, 800 * DIV);
                hs_last = k;
            end
            if (!hs_prev && d_hs) check_eq("hsync_low_width", k - hs_last, 96 * DIV);
            if (vs_prev && !s_vs) vs_last = k;
            if (!vs_prev && s_vs) check_eq("vsync_low_width", k - vs_last, S_VS * S_HT * DIV);
            if (s_fs) begin
                fs_n++;
                if (fs_n == 1) check_eq("frame_start_first", k, DIV - 1);
                else           check_eq("frame_start_period", k - fs_last, S_FT * DIV);
                fs_last = k;
            end
            hs_prev = d_hs;
            vs_prev = s_vs;
            rgb_in = 12'($urandom);
            if ($urandom_range(0, 63) == 0) test_mode = ~test_mode;
            if ((k % DIV) == DIV - 1) begin
                cap_d = (TP_EN && test_mode) ? bar(((k / DIV) % 420000) % 800) : rgb_in;
                cap_s = (TP_EN && test_mode) ? bar(((k / DIV) % S_FT) % S_HT) : rgb_in;
            end
            k++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] e;
        bit found;
        rst_n = 1'b0;
        rgb_in = 12'hFA0;
        test_mode = 1'b0;
        restart_tracking();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("reset_dflt", got_d(), RST_VEC);
            check_eq("reset_small", got_s(), RST_VEC);
        end

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run(10000);
        check_eq("hsync_fall_count", hs_falls, 3);
        check_eq("frame_start_count", fs_n, 3);

        run(2000 + $urandom_range(0, 300));
        found = 1'b0;
        for (int j = 0; j < 300 && !found; j++) begin
            e = exp_s(k);
            if (!e[13]) found = 1'b1;
            else        run(1);
        end
        check_eq("find_hsync_low", found, 1'b1);
        check_eq("hsync_low_before_reset", s_hs, 1'b0);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_dflt", got_d(), RST_VEC);
        check_eq("async_reset_small", got_s(), RST_VEC);
        @(negedge clk);
        #1;
        check_eq("reset_hold_small", got_s(), RST_VEC);

        @(negedge clk);
        rst_n = 1'b1;
        restart_tracking();
        #1;
        run(5000);
        check_eq("restart_hsync_falls", hs_falls, 1);
        check_eq("restart_frame_starts", fs_n, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel tick (100 MHz to 25 MHz).
REQ-002 Parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: 640x480@60 timing, in pixels and lines.
REQ-003 clk  input  1  system clock; the single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rgb_in  input  12  pixel colour {R4,G4,B4} returned by the renderer for the current pix_x/pix_y.
REQ-006 test_mode  input  1  selects the internal colour-bar pattern (see Configuration).
REQ-007 pix_x  output  10  active-area column 0..639 sent to the renderer.
REQ-008 pix_y  output  9  active-area row 0..479 sent to the renderer.
REQ-009 pix_valid  output  1  high while pix_x/pix_y are inside the active area.
REQ-010 pix_ce  output  1  one-clk pulse per pixel tick.
REQ-011 frame_start  output  1  one-clk pulse at the tick where h_cnt=0 and v_cnt=0.
REQ-012 hsync, vsync  output  1 each  negative-polarity syncs.
REQ-013 vga_r, vga_g, vga_b  output  4 each  registered colour to the DAC.

Function
REQ-014 Divider counts 0..CLK_DIV-1 and asserts pix_ce for one clk when count = CLK_DIV-1.
REQ-015 h_cnt (10 bit) advances on pix_ce and wraps from 799 to 0.
REQ-016 v_cnt (10 bit) advances on pix_ce only when h_cnt wraps, and wraps from 524 to 0.
REQ-017 Active area: h_cnt<640 and v_cnt<480.
REQ-018 Coordinates: pix_x=h_cnt and pix_y=v_cnt[8:0] when active; both 0 otherwise.
REQ-019 Coordinates are stable for the full CLK_DIV clks of a tick.
REQ-020 Raw hsync is low for h_cnt 656..751; raw vsync is low for v_cnt 490..491.
REQ-021 Output stage samples rgb_in on pix_ce, one clk before the counters advance, so renderer ROM latency up to CLK_DIV-1 clks is absorbed.
REQ-022 hsync, vsync and the active flag are delayed one pixel tick, aligned with the registered colour.
REQ-023 vga_r/g/b = 0 whenever the delayed active flag is low; rgb_in is ignored during blanking.
REQ-024 All outputs are registered except pix_ce.

Reset
REQ-025 On rst_n low, immediately: divider, h_cnt, v_cnt, pix_x, pix_y = 0; pix_valid, pix_ce, frame_start = 0; hsync, vsync = 1; vga_r/g/b = 0.
REQ-026 After rst_n rises, the first pix_ce occurs CLK_DIV clks later and frame_start pulses on that tick.
REQ-027 Reset mid-line or mid-frame abandons the frame with no partial sync pulse stretched beyond reset.

Configuration
REQ-028 Macro VGA_TEST_PATTERN_EN defined: with test_mode=1, the colour source is 8 vertical bars, each 80 px wide (white, yellow, cyan, green, magenta, red, blue, black), selected by h_cnt[9:0]/80; with test_mode=0, rgb_in is used.
REQ-029 Macro undefined: no bar logic is built, test_mode is ignored, and rgb_in is always used.

Structure
REQ-030 Package vga_pkg holds the timing constants, H_TOTAL=800, V_TOTAL=525, and typedefs coord_x_t [9:0], coord_y_t [8:0], rgb_t [11:0]; both the renderer and this block import it.
REQ-031 Sub-module vga_clk_en implements the divider (REQ-014) and outputs pix_ce.

Verification
REQ-032 Reset release -> hsync=vsync=1 and rgb=0 during reset; first pix_ce at clk 4; frame_start coincides with it.
REQ-033 Free-run -> hsync falling edges 3200 clks apart; low width 384 clks; first falling edge at tick 657 (656 plus one tick of alignment).
REQ-034 Free-run -> frame_start period 1,680,000 clks; vsync low width 6400 clks.
REQ-035 rgb_in=12'hFA0 constant -> vga_r=F, g=A, b=0 from tick 1 to tick 640 of each active line; 0 during blanking and for v_cnt>=480.
REQ-036 rst_n pulsed low at h_cnt=700, v_cnt=200 -> outputs return to reset values asynchronously; next frame restarts at (0,0).
REQ-037 With VGA_TEST_PATTERN_EN defined and test_mode=1 -> pixels 0..79 = FFF, 80..159 = FF0, 560..639 = 000, independent of rgb_in.
